// File: rtl/tpu_program_memory.sv
// Program store for the TEKITO processing unit, with a run-time byte loader.
// The CPU is held stopped (CPU_RUN low) while the memory is being cleared or loaded.
module tpu_program_memory #(
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    DATA_WIDTH  = 8,
    parameter bit                    INIT_CLEAR  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] MEMORY_ADDR,
    output logic [DATA_WIDTH-1:0] MEMORY_DATA,
    output logic                  CPU_RUN,
    input  logic                  LOAD_START,
    input  logic                  LOAD_VALID,
    input  logic [DATA_WIDTH-1:0] LOAD_DATA,
    input  logic                  LOAD_LAST,
    output logic                  LOAD_READY,
    output logic [ADDR_WIDTH:0]   LOAD_COUNT,
    output logic                  BUSY
);
    localparam int                  DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] PTR_ZERO = {(ADDR_WIDTH+1){1'b0}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam state_t RESET_STATE = INIT_CLEAR ? ST_CLEAR : ST_RUN;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_t                state_r,  state_nxt_s;
    logic [ADDR_WIDTH:0]   ptr_r,    ptr_nxt_s;
    logic [ADDR_WIDTH:0]   count_r,  count_nxt_s;
    logic                  cpu_run_r, cpu_run_nxt_s;
    logic                  ready_r,   ready_nxt_s;
    logic                  busy_r,    busy_nxt_s;
    logic                  mem_we_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    // State, pointer and registered-output update; RESET wins over everything
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r   <= RESET_STATE;
            ptr_r     <= PTR_ZERO;
            count_r   <= PTR_ZERO;
            cpu_run_r <= !INIT_CLEAR;
            ready_r   <= 1'b0;
            busy_r    <= INIT_CLEAR;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            count_r   <= count_nxt_s;
            cpu_run_r <= cpu_run_nxt_s;
            ready_r   <= ready_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Next-state, pointer and write-port decode
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        count_nxt_s = count_r;
        mem_we_s    = 1'b0;
        mem_wdata_s = CLEAR_VALUE;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s = 1'b1;
                if (ptr_r == PTR_LAST) begin
                    state_nxt_s = ST_RUN;
                    ptr_nxt_s   = PTR_ZERO;
                end else begin
                    ptr_nxt_s   = ptr_r + PTR_ONE;
                end
            end
            ST_RUN: begin
                if (LOAD_START) begin
                    state_nxt_s = ST_LOAD;
                    ptr_nxt_s   = PTR_ZERO;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (LOAD_VALID && ready_r) begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = LOAD_DATA;
                    // A load ends on LAST or after the final address; ptr never wraps
                    if (LOAD_LAST || (ptr_r == PTR_LAST)) begin
                        state_nxt_s = ST_RUN;
                        ptr_nxt_s   = PTR_ZERO;
                        count_nxt_s = ptr_r + PTR_ONE;
                    end else begin
                        ptr_nxt_s   = ptr_r + PTR_ONE;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            default: begin
                state_nxt_s = RESET_STATE;
                ptr_nxt_s   = PTR_ZERO;
            end
        endcase
    end

    // Output values for the state being entered, so outputs change on the same edge
    always_comb begin
        cpu_run_nxt_s = 1'b0;
        ready_nxt_s   = 1'b0;
        busy_nxt_s    = 1'b1;
        case (state_nxt_s)
            ST_RUN: begin
                cpu_run_nxt_s = 1'b1;
                busy_nxt_s    = 1'b0;
            end
            ST_LOAD: begin
                ready_nxt_s   = 1'b1;
            end
            ST_CLEAR: begin
                busy_nxt_s    = 1'b1;
            end
            default: begin
                busy_nxt_s    = 1'b1;
            end
        endcase
    end

    // Storage array: not reset, only written by CLEAR or accepted load bytes
    always_ff @(posedge CLOCK) begin
        if (mem_we_s && !RESET) begin
            mem_r[ptr_r[ADDR_WIDTH-1:0]] <= mem_wdata_s;
        end
    end

    assign MEMORY_DATA = mem_r[MEMORY_ADDR];
    assign CPU_RUN     = cpu_run_r;
    assign LOAD_READY  = ready_r;
    assign LOAD_COUNT  = count_r;
    assign BUSY        = busy_r;

endmodule
